// File: rtl/eth_frame_tx_gen2.sv
// Ethernet II frame transmitter: preamble/SFD, MAC header, payload stream with zero padding and overlength abort.
// Optional FCS (CRC-32, LSB byte first) appended when ETH_TX_FCS_EN is defined.
module eth_frame_tx_gen2 #(
   parameter int PREAMBLE_LEN = 7,
   parameter int MIN_PAYLOAD  = 46,
   parameter int MAX_PAYLOAD  = 1500,
   parameter int IFG_CYCLES   = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_start,
   input  logic [47:0] dest_mac,
   input  logic [47:0] src_mac,
   input  logic [15:0] ethertype,
   input  logic [7:0]  tx_data_in,
   input  logic        tx_data_valid,
   input  logic        tx_data_last,
   output logic        tx_ready,
   output logic        tx_ready_frame,
   output logic [7:0]  tx_data_out,
   output logic        tx_out_valid,
   output logic        tx_sof,
   output logic        tx_eof,
   output logic        tx_done,
   output logic        tx_err
);

   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_SFD, S_DST, S_SRC, S_TYPE,
      S_PAY, S_PEND, S_PAD, S_FCS, S_IFG
   } state_t;

   localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
   localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);
   localparam logic [13:0] MIN_CNT  = 14'(MIN_PAYLOAD);
   localparam logic [13:0] PAD_LAST = 14'(MIN_PAYLOAD - 1);
   localparam logic [13:0] MAX_LAST = 14'(MAX_PAYLOAD - 1);
   localparam logic [13:0] CNT_SAT  = 14'h3FFF;
`ifdef ETH_TX_FCS_EN
   localparam logic FCS_ON = 1'b1;
`else
   localparam logic FCS_ON = 1'b0;
`endif

   state_t      state_reg, state_next;
   logic [15:0] cnt_reg;
   logic [13:0] pay_cnt_reg;
   logic [7:0]  data_reg;
   logic        data_vld_reg;
   logic        ovl_reg;
   logic [47:0] dst_reg, src_reg;
   logic [15:0] type_reg;
   logic [47:0] dst_sh, src_sh;
   logic [7:0]  fcs_byte;
   logic        accept;
   logic        pay_inc;

   assign accept  = (state_reg == S_PAY) && tx_data_valid;
   assign pay_inc = accept || (state_reg == S_PAD);
   assign dst_sh  = dst_reg << {cnt_reg[2:0], 3'b000};
   assign src_sh  = src_reg << {cnt_reg[2:0], 3'b000};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= S_IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (tx_start) state_next = S_PRE;
         S_PRE:  if (cnt_reg == PRE_LAST) state_next = S_SFD;
         S_SFD:  state_next = S_DST;
         S_DST:  if (cnt_reg == 16'd5) state_next = S_SRC;
         S_SRC:  if (cnt_reg == 16'd5) state_next = S_TYPE;
         S_TYPE: if (cnt_reg == 16'd1) state_next = S_PAY;
         // The final byte (last flag or length limit) is drained in S_PEND with tx_ready low.
         S_PAY:  if (accept && (tx_data_last || pay_cnt_reg == MAX_LAST)) state_next = S_PEND;
         S_PEND: begin
            if (ovl_reg)                  state_next = S_IFG;
            else if (pay_cnt_reg < MIN_CNT) state_next = S_PAD;
            else if (FCS_ON)              state_next = S_FCS;
            else                          state_next = S_IFG;
         end
         S_PAD:  if (pay_cnt_reg == PAD_LAST) state_next = FCS_ON ? S_FCS : S_IFG;
         S_FCS:  if (cnt_reg == 16'd3) state_next = S_IFG;
         S_IFG:  if (cnt_reg == IFG_LAST) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg      <= '0;
         pay_cnt_reg  <= '0;
         data_reg     <= '0;
         data_vld_reg <= 1'b0;
         ovl_reg      <= 1'b0;
         dst_reg      <= '0;
         src_reg      <= '0;
         type_reg     <= '0;
      end else begin
         if (state_reg == S_IDLE || state_next != state_reg) cnt_reg <= '0;
         else                                               cnt_reg <= cnt_reg + 16'd1;
         data_vld_reg <= accept;
         if (accept) begin
            data_reg <= tx_data_in;
            ovl_reg  <= !tx_data_last && (pay_cnt_reg == MAX_LAST);
         end
         if (state_reg == S_IDLE) begin
            pay_cnt_reg <= '0;
            ovl_reg     <= 1'b0;
            if (tx_start) begin
               dst_reg  <= dest_mac;
               src_reg  <= src_mac;
               type_reg <= ethertype;
            end
         end else if (pay_inc && pay_cnt_reg != CNT_SAT) begin
            pay_cnt_reg <= pay_cnt_reg + 14'd1;
         end
      end
   end

`ifdef ETH_TX_FCS_EN
   logic [31:0] crc_reg;
   logic [31:0] fcs_sh;
   logic        crc_en;

   // Reflected CRC-32, one byte per cycle, LSB of each byte first.
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   assign crc_en   = tx_out_valid && (state_reg inside {S_DST, S_SRC, S_TYPE, S_PAY, S_PEND, S_PAD});
   assign fcs_sh   = ~crc_reg >> {cnt_reg[1:0], 3'b000};
   assign fcs_byte = fcs_sh[7:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                    crc_reg <= 32'hFFFFFFFF;
      else if (state_reg == S_IDLE) crc_reg <= 32'hFFFFFFFF;
      else if (crc_en)             crc_reg <= crc_byte(crc_reg, tx_data_out);
   end
`else
   assign fcs_byte = 8'h00;
`endif

   always_comb begin
      tx_ready       = (state_reg == S_PAY);
      tx_ready_frame = (state_reg == S_IDLE);
      tx_data_out    = 8'h00;
      tx_out_valid   = 1'b0;
      tx_sof         = 1'b0;
      tx_eof         = 1'b0;
      tx_done        = 1'b0;
      tx_err         = 1'b0;
      case (state_reg)
         S_PRE: begin
            tx_data_out  = 8'h55;
            tx_out_valid = 1'b1;
            tx_sof       = (cnt_reg == 16'd0);
         end
         S_SFD: begin
            tx_data_out  = 8'hD5;
            tx_out_valid = 1'b1;
         end
         S_DST: begin
            tx_data_out  = dst_sh[47:40];
            tx_out_valid = 1'b1;
         end
         S_SRC: begin
            tx_data_out  = src_sh[47:40];
            tx_out_valid = 1'b1;
         end
         S_TYPE: begin
            tx_data_out  = cnt_reg[0] ? type_reg[7:0] : type_reg[15:8];
            tx_out_valid = 1'b1;
         end
         S_PAY: begin
            tx_data_out  = data_reg;
            tx_out_valid = data_vld_reg;
         end
         S_PEND: begin
            tx_data_out  = data_reg;
            tx_out_valid = 1'b1;
            tx_err       = ovl_reg;
            tx_eof       = ovl_reg || (!FCS_ON && pay_cnt_reg >= MIN_CNT);
         end
         S_PAD: begin
            tx_out_valid = 1'b1;
            tx_eof       = !FCS_ON && (pay_cnt_reg == PAD_LAST);
         end
         S_FCS: begin
            tx_data_out  = fcs_byte;
            tx_out_valid = 1'b1;
            tx_eof       = (cnt_reg == 16'd3);
         end
         S_IFG: tx_done = (cnt_reg == 16'd0);
         default: ;
      endcase
   end

endmodule

// File: tb/tb_eth_frame_tx_gen2.sv
// Directed testbench for eth_frame_tx_gen2: header/payload/pad framing, underrun bubbles,
// overlength abort, mid-frame reset and back-to-back frames. FCS checks follow ETH_TX_FCS_EN.
module tb_eth_frame_tx_gen2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        tx_start = 1'b0;
   logic [47:0] dest_mac = '0;
   logic [47:0] src_mac = '0;
   logic [15:0] ethertype = '0;
   logic [7:0]  tx_data_in = '0;
   logic        tx_data_valid = 1'b0;
   logic        tx_data_last = 1'b0;
   logic        tx_ready, tx_ready_frame, tx_out_valid, tx_sof, tx_eof, tx_done, tx_err;
   logic [7:0]  tx_data_out;

`ifdef ETH_TX_FCS_EN
   localparam int FCS_LEN = 4;
`else
   localparam int FCS_LEN = 0;
`endif
   // 8 preamble/SFD + 14 header + 46 payload/pad (+ 4 FCS)
   localparam int LEN_MIN_FRAME = 68 + FCS_LEN;

   localparam logic [47:0] D1 = 48'hAABBCCDDEEFF;
   localparam logic [47:0] S1 = 48'h112233445566;
   localparam logic [15:0] T1 = 16'h0800;

   eth_frame_tx_gen2 dut (
      .clk(clk), .rst(rst), .tx_start(tx_start), .dest_mac(dest_mac), .src_mac(src_mac),
      .ethertype(ethertype), .tx_data_in(tx_data_in), .tx_data_valid(tx_data_valid),
      .tx_data_last(tx_data_last), .tx_ready(tx_ready), .tx_ready_frame(tx_ready_frame),
      .tx_data_out(tx_data_out), .tx_out_valid(tx_out_valid), .tx_sof(tx_sof),
      .tx_eof(tx_eof), .tx_done(tx_done), .tx_err(tx_err)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   logic [7:0] cap_data[$];
   bit         cap_sof[$];
   bit         cap_eof[$];
   bit         cap_err[$];
   int         cap_cyc[$];
   int         done_cnt = 0;
   int         done_cyc = -1;
   int         err_cnt = 0;
   int         eof_cnt = 0;
   logic [7:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         if (tx_out_valid) begin
            cap_data.push_back(tx_data_out);
            cap_sof.push_back(tx_sof);
            cap_eof.push_back(tx_eof);
            cap_err.push_back(tx_err);
            cap_cyc.push_back(cyc);
         end
         if (tx_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
         end
         if (tx_err) err_cnt <= err_cnt + 1;
         if (tx_eof) eof_cnt <= eof_cnt + 1;
      end
   end

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      logic        fb;
      r = c;
      for (int b = 0; b < 8; b++) begin
         fb = r[0] ^ d[b];
         r  = r >> 1;
         if (fb) r = r ^ 32'hEDB88320;
      end
      return r;
   endfunction

   function automatic int diff_count(input int off, output int first);
      int n;
      n = 0;
      first = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (off + i >= cap_data.size() || cap_data[off + i] !== exp_q[i]) begin
            n++;
            if (first < 0) first = i;
         end
      end
      return n;
   endfunction

   task automatic clear_mon();
      cap_data.delete(); cap_sof.delete(); cap_eof.delete(); cap_err.delete(); cap_cyc.delete();
   endtask

   task automatic build_exp(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                            input int n, input logic [7:0] base, input bit ovl);
      int plen;
      int sz;
      logic [31:0] crc;
      exp_q.delete();
      for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      for (int i = 5; i >= 0; i--) exp_q.push_back(d[8*i +: 8]);
      for (int i = 5; i >= 0; i--) exp_q.push_back(s[8*i +: 8]);
      exp_q.push_back(t[15:8]);
      exp_q.push_back(t[7:0]);
      for (int i = 0; i < n; i++) exp_q.push_back(8'(base + i));
      plen = n;
      if (!ovl) begin
         while (plen < 46) begin
            exp_q.push_back(8'h00);
            plen++;
         end
         if (FCS_LEN == 4) begin
            crc = 32'hFFFFFFFF;
            sz = exp_q.size();
            for (int i = 8; i < sz; i++) crc = crc_upd(crc, exp_q[i]);
            crc = ~crc;
            for (int k = 0; k < 4; k++) exp_q.push_back(crc[8*k +: 8]);
         end
      end
   endtask

   task automatic start_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
      dest_mac = d; src_mac = s; ethertype = t;
      tx_start = 1'b1;
      @(posedge clk); #1;
      tx_start = 1'b0;
      dest_mac = '0; src_mac = '0; ethertype = '0;
   endtask

   // Offers n payload bytes; stops early if an overlength abort is seen.
   task automatic feed(input int n, input logic [7:0] base, input bit use_last,
                       input int gap_at, input int gap_len, input int budget, output int acc);
      int g;
      int err0;
      bit xfer;
      g = gap_len;
      acc = 0;
      err0 = err_cnt;
      for (int c = 0; c < budget && acc < n && err_cnt == err0; c++) begin
         if (acc == gap_at && g > 0) begin
            tx_data_valid = 1'b0;
            g--;
         end else begin
            tx_data_valid = 1'b1;
            tx_data_in    = 8'(base + acc);
            tx_data_last  = use_last && (acc == n - 1);
         end
         @(negedge clk);
         xfer = tx_data_valid && tx_ready;
         @(posedge clk); #1;
         if (xfer) acc++;
      end
      tx_data_valid = 1'b0;
      tx_data_last  = 1'b0;
   endtask

   task automatic wait_done(input int snap, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         @(negedge clk);
         if (done_cnt > snap) ok = 1'b1;
      end
      for (int c = 0; c < 40 && !tx_ready_frame; c++) @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (tx_ready_frame !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_ready_frame: got %b want 1", tx_ready_frame);
      end
      tests_run++;
      if ({tx_out_valid, tx_sof, tx_eof, tx_done, tx_err, tx_ready} !== 6'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b want 000000",
                  {tx_out_valid, tx_sof, tx_eof, tx_done, tx_err, tx_ready});
      end
      tests_run++;
      if (tx_data_out !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_data: got %h want 00", tx_data_out);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      $display("[TB] reset released");
   endtask

   task automatic test_basic_frame();
      int acc, first, nd, last, d0;
      bit ok;
      logic [31:0] r, rb;
      clear_mon();
      d0 = done_cnt;
      build_exp(D1, S1, T1, 16, 8'hBA, 1'b0);
      start_frame(D1, S1, T1);
      feed(16, 8'hBA, 1'b1, -1, 0, 200, acc);
      wait_done(d0, 200, ok);
      $display("[TB] basic frame: %0d bytes, %0d payload accepted", cap_data.size(), acc);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL basic_done_timeout: got no tx_done want pulse"); end
      tests_run++;
      if (cap_data.size() != LEN_MIN_FRAME) begin
         tests_failed++;
         $display("FAIL basic_len: got %0d want %0d", cap_data.size(), LEN_MIN_FRAME);
      end
      nd = diff_count(0, first);
      tests_run++;
      if (nd != 0) begin
         tests_failed++;
         $display("FAIL basic_bytes: %0d wrong, first at %0d got %h want %h", nd, first,
                  (first < cap_data.size()) ? cap_data[first] : 8'hxx, exp_q[first]);
      end
      tests_run++;
      if (cap_data.size() > 22 && {cap_data[0], cap_data[7], cap_data[8], cap_data[20], cap_data[22]} !== 40'h55D5AA08BA) begin
         tests_failed++;
         $display("FAIL basic_key_bytes: got %h want 55d5aa08ba",
                  {cap_data[0], cap_data[7], cap_data[8], cap_data[20], cap_data[22]});
      end
      last = cap_data.size() - 1;
      tests_run++;
      if (last < 1 || cap_sof[0] !== 1'b1 || cap_sof[1] !== 1'b0 || cap_eof[last] !== 1'b1 || cap_eof[last-1] !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_sof_eof: got sof0/eof_last wrong want sof on first, eof on last only");
      end
      tests_run++;
      if (last < 0 || done_cyc != cap_cyc[last] + 1) begin
         tests_failed++;
         $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, (last >= 0) ? cap_cyc[last] + 1 : -1);
      end
      tests_run++;
      if (err_cnt != 0) begin
         tests_failed++;
         $display("FAIL basic_no_err: got %0d err pulses want 0", err_cnt);
      end
`ifdef ETH_TX_FCS_EN
      r = 32'hFFFFFFFF;
      for (int i = 8; i < cap_data.size(); i++) r = crc_upd(r, cap_data[i]);
      for (int b = 0; b < 32; b++) rb[b] = r[31-b];
      tests_run++;
      if (rb !== 32'hC704DD7B) begin
         tests_failed++;
         $display("FAIL fcs_residue: got %h want c704dd7b", rb);
      end
`else
      r = '0; rb = r;
`endif
   endtask

   task automatic test_underrun();
      int acc, first, nd, bub, d0;
      bit ok;
      clear_mon();
      d0 = done_cnt;
      build_exp(S1, D1, 16'h86DD, 60, 8'h20, 1'b0);
      start_frame(S1, D1, 16'h86DD);
      feed(60, 8'h20, 1'b1, 30, 3, 300, acc);
      wait_done(d0, 200, ok);
      $display("[TB] underrun frame: %0d bytes, %0d payload accepted", cap_data.size(), acc);
      tests_run++;
      if (!ok || cap_data.size() != 82 + FCS_LEN) begin
         tests_failed++;
         $display("FAIL underrun_len: got %0d (done %0b) want %0d", cap_data.size(), ok, 82 + FCS_LEN);
      end
      nd = diff_count(0, first);
      tests_run++;
      if (nd != 0) begin
         tests_failed++;
         $display("FAIL underrun_bytes: %0d wrong, first at %0d", nd, first);
      end
      bub = (cap_cyc.size() > 81) ? cap_cyc[81] - cap_cyc[22] + 1 - 60 : -1;
      tests_run++;
      if (bub != 3) begin
         tests_failed++;
         $display("FAIL underrun_bubbles: got %0d want 3", bub);
      end
   endtask

   task automatic test_overlength();
      int acc, first, nd, last, e0, d0;
      bit ok;
      clear_mon();
      e0 = err_cnt;
      d0 = done_cnt;
      build_exp(D1, S1, T1, 1500, 8'h00, 1'b1);
      start_frame(D1, S1, T1);
      feed(1501, 8'h00, 1'b0, -1, 0, 2000, acc);
      tx_data_valid = 1'b1;
      tx_data_in = 8'hEE;
      wait_done(d0, 50, ok);
      $display("[TB] overlength frame: %0d bytes, %0d payload accepted", cap_data.size(), acc);
      tests_run++;
      if (acc != 1500) begin
         tests_failed++;
         $display("FAIL ovl_accepted: got %0d want 1500", acc);
      end
      tests_run++;
      if (!ok || cap_data.size() != 1522) begin
         tests_failed++;
         $display("FAIL ovl_len: got %0d (done %0b) want 1522", cap_data.size(), ok);
      end
      nd = diff_count(0, first);
      tests_run++;
      if (nd != 0) begin
         tests_failed++;
         $display("FAIL ovl_bytes: %0d wrong, first at %0d", nd, first);
      end
      last = cap_data.size() - 1;
      tests_run++;
      if (last < 0 || cap_eof[last] !== 1'b1 || cap_err[last] !== 1'b1 || err_cnt != e0 + 1) begin
         tests_failed++;
         $display("FAIL ovl_err_eof: got err pulses %0d want 1 with eof on last byte", err_cnt - e0);
      end
      @(negedge clk);
      tests_run++;
      if (tx_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL ovl_ready_after: got %b want 0", tx_ready);
      end
      @(posedge clk); #1;
      tx_data_valid = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      int acc, first, nd, e0, d0;
      bit ok;
      clear_mon();
      start_frame(D1, S1, T1);
      for (int c = 0; c < 40 && cap_data.size() < 16; c++) @(negedge clk);
      tests_run++;
      if (cap_data.size() < 16) begin
         tests_failed++;
         $display("FAIL midrst_reach_src: got %0d bytes want >= 16", cap_data.size());
      end
      e0 = eof_cnt;
      d0 = done_cnt;
      #2 rst = 1'b0;
      #1;
      tests_run++;
      if (tx_out_valid !== 1'b0 || tx_data_out !== 8'h00 || tx_ready_frame !== 1'b1) begin
         tests_failed++;
         $display("FAIL midrst_async: got valid=%b data=%h rdyf=%b want 0 00 1",
                  tx_out_valid, tx_data_out, tx_ready_frame);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      tests_run++;
      if (eof_cnt != e0 || done_cnt != d0) begin
         tests_failed++;
         $display("FAIL midrst_no_eof_done: got eof %0d done %0d want none", eof_cnt - e0, done_cnt - d0);
      end
      clear_mon();
      build_exp(D1, S1, T1, 50, 8'h01, 1'b0);
      start_frame(D1, S1, T1);
      feed(50, 8'h01, 1'b1, -1, 0, 200, acc);
      wait_done(d0, 200, ok);
      $display("[TB] post-reset frame: %0d bytes", cap_data.size());
      nd = diff_count(0, first);
      tests_run++;
      if (!ok || nd != 0 || cap_data.size() != 72 + FCS_LEN) begin
         tests_failed++;
         $display("FAIL midrst_fresh_frame: got %0d bytes %0d wrong want %0d exact", cap_data.size(), nd, 72 + FCS_LEN);
      end
   endtask

   task automatic test_back_to_back();
      int acc1, acc2, first, nd, d0, gap;
      int sofs[$];
      bit ok;
      clear_mon();
      d0 = done_cnt;
      dest_mac = D1; src_mac = S1; ethertype = T1;
      tx_start = 1'b1;
      feed(4, 8'h40, 1'b1, -1, 0, 200, acc1);
      feed(4, 8'h50, 1'b1, -1, 0, 300, acc2);
      tx_start = 1'b0;
      wait_done(d0 + 1, 200, ok);
      repeat (20) @(posedge clk);
      #1;
      for (int i = 0; i < cap_sof.size(); i++) if (cap_sof[i]) sofs.push_back(i);
      $display("[TB] back-to-back: %0d frames, %0d bytes", sofs.size(), cap_data.size());
      tests_run++;
      if (!ok || sofs.size() != 2 || cap_data.size() != 2 * LEN_MIN_FRAME) begin
         tests_failed++;
         $display("FAIL b2b_frames: got %0d frames %0d bytes want 2 frames %0d bytes",
                  sofs.size(), cap_data.size(), 2 * LEN_MIN_FRAME);
      end
      if (sofs.size() == 2 && sofs[1] > 0) begin
         gap = cap_cyc[sofs[1]] - cap_cyc[sofs[1] - 1];
         tests_run++;
         if (gap != 14 || cap_eof[sofs[1] - 1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_gap: got eof->sof %0d cycles want 14", gap);
         end
         build_exp(D1, S1, T1, 4, 8'h50, 1'b0);
         nd = diff_count(sofs[1], first);
         tests_run++;
         if (nd != 0) begin
            tests_failed++;
            $display("FAIL b2b_frame2_bytes: %0d wrong, first at %0d", nd, first);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_underrun();
      test_overlength();
      test_reset_mid_frame();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
